// File: rtl/lut_pkg.sv
// Shared types and constants for the programmable branch-target lookup table.
package lut_pkg;

   // Index geometry formerly hard-coded in the fixed PC-target LUT.
   localparam int LUT_AW    = 10;
   localparam int LUT_IW    = 4;
   localparam int LUT_DEPTH = 16;

   localparam logic [LUT_AW-1:0] LUT_DEFAULT_TARGET = 10'h001;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } lut_state_t;

   typedef struct packed {
      logic              valid;
      logic              rel;
      logic [LUT_AW-1:0] data;
   } lut_entry_t;

   function automatic lut_entry_t lut_make_entry(input logic rel, input logic [LUT_AW-1:0] data);
      lut_entry_t e;
      e.valid = 1'b1;
      e.rel   = rel;
      e.data  = data;
      return e;
   endfunction

endpackage

// File: rtl/lut_target_ram.sv
// Entry storage: one synchronous write port, one combinational read port.
module lut_target_ram
   import lut_pkg::*;
#(
   parameter int IW    = LUT_IW,
   parameter int DEPTH = LUT_DEPTH
) (
   input  logic          clk_i,
   input  logic          wr_en_i,
   input  logic [IW-1:0] wr_idx_i,
   input  lut_entry_t    wr_entry_i,
   input  logic [IW-1:0] rd_idx_i,
   output lut_entry_t    rd_entry_o
);

   lut_entry_t mem_q [DEPTH];

   // NOTE: no reset on the array; the top's INIT sweep clears it one entry per cycle.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_idx_i] <= wr_entry_i;
      end
   end

   assign rd_entry_o = (int'(rd_idx_i) < DEPTH) ? mem_q[rd_idx_i] : '0;

endmodule

// File: rtl/lut_target_table.sv
// Programmable branch-target LUT: INIT sweep, run-time writes, 1-cycle registered lookup.
// AW must equal lut_pkg::LUT_AW because the entry struct carries the data field.
module lut_target_table
   import lut_pkg::*;
#(
   parameter int              AW             = LUT_AW,
   parameter int              IW             = LUT_IW,
   parameter int              DEPTH          = LUT_DEPTH,
   parameter logic [AW-1:0]   DEFAULT_TARGET = LUT_DEFAULT_TARGET
) (
   input  logic          Clk,
   input  logic          Reset_n,
   output logic          Ready,
   input  logic          Rd_Req,
   input  logic [IW-1:0] Rd_Idx,
   input  logic [AW-1:0] Rd_PC,
   output logic          Rd_Valid,
   output logic [AW-1:0] Rd_Target,
   output logic          Rd_Miss,
   input  logic          Wr_En,
   input  logic [IW-1:0] Wr_Idx,
   input  logic [AW-1:0] Wr_Data,
   input  logic          Wr_Rel
);

   lut_state_t    state_q, state_d;
   logic [IW-1:0] cnt_q, cnt_d;
   logic          ready_q;
   logic          valid_q, miss_q;
   logic [AW-1:0] target_q;

   logic          run;
   logic          rd_accept;
   logic          wr_in_range;
   logic          rd_in_range;
   logic          ram_we;
   logic [IW-1:0] ram_widx;
   lut_entry_t    ram_wentry;
   lut_entry_t    ram_rentry;
   lut_entry_t    rd_entry;
   logic          rd_miss;
   logic [AW-1:0] rd_target;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q <= INIT;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= (state_d == RUN);
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == INIT) begin
         cnt_d = cnt_q + 1'b1;
         if (int'(cnt_q) == DEPTH - 1) begin
            state_d = RUN;
            cnt_d   = '0;
         end
      end
   end

   always_comb begin
      run         = (state_q == RUN);
      wr_in_range = (int'(Wr_Idx) < DEPTH);
      rd_in_range = (int'(Rd_Idx) < DEPTH);
      rd_accept   = run && Rd_Req;
      ram_we      = 1'b0;
      ram_widx    = cnt_q;
      ram_wentry  = '0;
      if (!run) begin
         ram_we = Reset_n;
      end else if (Wr_En && wr_in_range) begin
         ram_we     = Reset_n;
         ram_widx   = Wr_Idx;
         ram_wentry = lut_make_entry(Wr_Rel, Wr_Data);
      end
   end

   lut_target_ram #(
      .IW    (IW),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk_i      (Clk),
      .wr_en_i    (ram_we),
      .wr_idx_i   (ram_widx),
      .wr_entry_i (ram_wentry),
      .rd_idx_i   (Rd_Idx),
      .rd_entry_o (ram_rentry)
   );

   // A same-cycle write to the looked-up index is forwarded to the response.
   always_comb begin
      rd_entry = ram_rentry;
      if (run && Wr_En && wr_in_range && (Wr_Idx == Rd_Idx)) begin
         rd_entry = ram_wentry;
      end
      rd_miss   = !rd_in_range || !rd_entry.valid;
      rd_target = rd_entry.data;
      if (rd_miss) begin
         rd_target = DEFAULT_TARGET;
      end else if (rd_entry.rel) begin
         rd_target = Rd_PC + rd_entry.data;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         valid_q  <= 1'b0;
         miss_q   <= 1'b0;
         target_q <= '0;
      end else begin
         valid_q <= rd_accept;
         if (rd_accept) begin
            miss_q   <= rd_miss;
            target_q <= rd_target;
         end
      end
   end

   assign Ready     = ready_q;
   assign Rd_Valid  = valid_q;
   assign Rd_Miss   = miss_q;
   assign Rd_Target = target_q;

endmodule

// File: tb/tb_lut_target_table.sv
// Self-checking bench: directed vector table, reset sequences, randomized run against a reference model.
module tb_lut_target_table;

   localparam int AW    = 10;
   localparam int IW    = 4;
   localparam int DEPTH = 16;

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic          Ready;
   logic          Rd_Req = 1'b0;
   logic [IW-1:0] Rd_Idx = '0;
   logic [AW-1:0] Rd_PC = '0;
   logic          Rd_Valid;
   logic [AW-1:0] Rd_Target;
   logic          Rd_Miss;
   logic          Wr_En = 1'b0;
   logic [IW-1:0] Wr_Idx = '0;
   logic [AW-1:0] Wr_Data = '0;
   logic          Wr_Rel = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   lut_target_table #(
      .AW             (AW),
      .IW             (IW),
      .DEPTH          (DEPTH),
      .DEFAULT_TARGET (10'h001)
   ) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .Ready     (Ready),
      .Rd_Req    (Rd_Req),
      .Rd_Idx    (Rd_Idx),
      .Rd_PC     (Rd_PC),
      .Rd_Valid  (Rd_Valid),
      .Rd_Target (Rd_Target),
      .Rd_Miss   (Rd_Miss),
      .Wr_En     (Wr_En),
      .Wr_Idx    (Wr_Idx),
      .Wr_Data   (Wr_Data),
      .Wr_Rel    (Wr_Rel)
   );

   typedef struct {
      logic          we;
      logic [IW-1:0] widx;
      logic [AW-1:0] wdata;
      logic          wrel;
      logic          req;
      logic [IW-1:0] ridx;
      logic [AW-1:0] pc;
      logic          exp_valid;
      logic          exp_miss;
      logic [AW-1:0] exp_target;
   } vec_t;

   vec_t vecs [$];

   // Reference model: plain arrays of what has been programmed since the last reset.
   bit            m_valid [DEPTH];
   bit            m_rel   [DEPTH];
   logic [AW-1:0] m_data  [DEPTH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [IW-1:0] widx, input logic [AW-1:0] wdata,
                               input logic wrel, input logic req, input logic [IW-1:0] ridx,
                               input logic [AW-1:0] pc, input logic ev, input logic em,
                               input logic [AW-1:0] et);
      vec_t v;
      v.we = we; v.widx = widx; v.wdata = wdata; v.wrel = wrel;
      v.req = req; v.ridx = ridx; v.pc = pc;
      v.exp_valid = ev; v.exp_miss = em; v.exp_target = et;
      return v;
   endfunction

   function automatic logic [AW-1:0] model_lookup(input int idx, input int pc, output bit miss);
      int off;
      if (idx >= DEPTH || !m_valid[idx]) begin
         miss = 1'b1;
         return 10'h001;
      end
      miss = 1'b0;
      if (!m_rel[idx]) return m_data[idx];
      off = (int'(m_data[idx]) >= 512) ? int'(m_data[idx]) - 1024 : int'(m_data[idx]);
      return AW'((pc + off + 1024) % 1024);
   endfunction

   // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
   task automatic apply(input logic we, input logic [IW-1:0] widx, input logic [AW-1:0] wdata,
                        input logic wrel, input logic req, input logic [IW-1:0] ridx,
                        input logic [AW-1:0] pc);
      @(negedge Clk);
      Wr_En = we; Wr_Idx = widx; Wr_Data = wdata; Wr_Rel = wrel;
      Rd_Req = req; Rd_Idx = ridx; Rd_PC = pc;
      @(posedge Clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},  Ready,     0);
      check({tag, "_valid"},  Rd_Valid,  0);
      check({tag, "_miss"},   Rd_Miss,   0);
      check({tag, "_target"}, Rd_Target, 0);
   endtask

   // Called on the falling edge right after Reset_n rises; Rd_Req stays high throughout INIT.
   task automatic wait_init(input string tag);
      for (int k = 0; k <= DEPTH; k++) begin
         check($sformatf("%s_ready_c%0d", tag, k), Ready, (k == DEPTH) ? 1 : 0);
         check($sformatf("%s_valid_c%0d", tag, k), Rd_Valid, 0);
         if (k < DEPTH) @(negedge Clk);
      end
      Rd_Req = 1'b0;
      Wr_En  = 1'b0;
   endtask

   initial begin
      logic [AW-1:0] last_t;
      logic          last_m;
      bit            em;
      logic [AW-1:0] et;

      // Power-up reset, with a request and a write held active the whole time.
      Reset_n = 1'b0; Rd_Req = 1'b1; Rd_Idx = 4'd2;
      Wr_En = 1'b1; Wr_Idx = 4'd4; Wr_Data = 10'h2AA; Wr_Rel = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      check_reset_outputs("por");
      @(negedge Clk);
      Reset_n = 1'b1;
      wait_init("por");

      vecs.push_back(mk(0, 0, 10'h000, 0, 1, 5, 10'h000, 1, 1, 10'h001));
      vecs.push_back(mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 1, 10'h001));
      vecs.push_back(mk(1, 2, 10'h3C0, 0, 0, 0, 10'h000, 0, 1, 10'h001));
      vecs.push_back(mk(0, 0, 10'h000, 0, 1, 2, 10'h123, 1, 0, 10'h3C0));
      vecs.push_back(mk(1, 3, 10'h3FF, 1, 0, 0, 10'h000, 0, 0, 10'h3C0));
      vecs.push_back(mk(0, 0, 10'h000, 0, 1, 3, 10'h010, 1, 0, 10'h00F));
      vecs.push_back(mk(0, 0, 10'h000, 0, 1, 3, 10'h000, 1, 0, 10'h3FF));
      vecs.push_back(mk(1, 7, 10'h055, 0, 1, 7, 10'h000, 1, 0, 10'h055));
      vecs.push_back(mk(0, 0, 10'h000, 0, 1, 15, 10'h000, 1, 1, 10'h001));
      vecs.push_back(mk(0, 0, 10'h000, 0, 1, 7, 10'h000, 1, 0, 10'h055));
      vecs.push_back(mk(1, 2, 10'h100, 0, 1, 3, 10'h200, 1, 0, 10'h1FF));
      vecs.push_back(mk(0, 0, 10'h000, 0, 1, 2, 10'h000, 1, 0, 10'h100));
      vecs.push_back(mk(0, 0, 10'h000, 0, 1, 4, 10'h000, 1, 1, 10'h001));
      vecs.push_back(mk(1, 9, 10'h005, 1, 1, 9, 10'h3FE, 1, 0, 10'h003));
      vecs.push_back(mk(0, 0, 10'h000, 0, 0, 9, 10'h000, 0, 0, 10'h003));

      foreach (vecs[i]) begin
         apply(vecs[i].we, vecs[i].widx, vecs[i].wdata, vecs[i].wrel,
               vecs[i].req, vecs[i].ridx, vecs[i].pc);
         check($sformatf("vec%0d_valid", i),  Rd_Valid,  vecs[i].exp_valid);
         check($sformatf("vec%0d_miss", i),   Rd_Miss,   vecs[i].exp_miss);
         check($sformatf("vec%0d_target", i), Rd_Target, vecs[i].exp_target);
      end

      // One-cycle reset in RUN with a request and a write in the same cycle: reset wins.
      @(negedge Clk);
      Reset_n = 1'b0; Rd_Req = 1'b1; Rd_Idx = 4'd2;
      Wr_En = 1'b1; Wr_Idx = 4'd6; Wr_Data = 10'h123; Wr_Rel = 1'b0;
      @(posedge Clk);
      #1;
      check_reset_outputs("mid");
      @(negedge Clk);
      Reset_n = 1'b1;
      wait_init("mid");

      apply(0, 0, 10'h000, 0, 1, 2, 10'h000);
      check("mid_rd2_valid", Rd_Valid, 1);
      check("mid_rd2_miss", Rd_Miss, 1);
      check("mid_rd2_target", Rd_Target, 10'h001);
      apply(0, 0, 10'h000, 0, 1, 6, 10'h000);
      check("mid_rd6_miss", Rd_Miss, 1);
      check("mid_rd6_target", Rd_Target, 10'h001);
      apply(0, 0, 10'h000, 0, 0, 0, 10'h000);
      check("mid_idle_valid", Rd_Valid, 0);

      // Randomized traffic against the model, which starts empty after the reset above.
      for (int i = 0; i < DEPTH; i++) begin
         m_valid[i] = 1'b0; m_rel[i] = 1'b0; m_data[i] = '0;
      end
      last_t = 10'h001;
      last_m = 1'b1;
      for (int n = 0; n < 400; n++) begin
         logic          we, wrel, req;
         logic [IW-1:0] widx, ridx;
         logic [AW-1:0] wdata, pc;
         we    = ($urandom_range(0, 2) == 0);
         widx  = IW'($urandom_range(0, DEPTH - 1));
         wdata = AW'($urandom);
         wrel  = 1'($urandom);
         req   = ($urandom_range(0, 2) != 0);
         ridx  = (n % 4 == 0) ? widx : IW'($urandom_range(0, DEPTH - 1));
         pc    = AW'($urandom);
         apply(we, widx, wdata, wrel, req, ridx, pc);
         if (we) begin
            m_valid[widx] = 1'b1;
            m_rel[widx]   = wrel;
            m_data[widx]  = wdata;
         end
         if (req) begin
            et = model_lookup(int'(ridx), int'(pc), em);
            last_t = et;
            last_m = em;
         end
         check($sformatf("rnd%0d_valid", n),  Rd_Valid,  req);
         check($sformatf("rnd%0d_miss", n),   Rd_Miss,   last_m);
         check($sformatf("rnd%0d_target", n), Rd_Target, last_t);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lut_target_table.md
Name: lut_target_table

Overview:
- Programmable branch-target lookup table, the parametrised successor of the fixed PC-target LUT.
- Maps a small index from the instruction to a full-width PC target. Entries are written at run time rather than hard-coded.
- Each entry is either an absolute target or a PC-relative signed offset.
- Sits beside the fetch/PC logic. It is filled by the loader or program-setup path and read once per branch with a 1-cycle registered response.

Parameters:
- AW, 10, PC/target width in bits.
- IW, 4, index width in bits.
- DEPTH, 16, number of entries (≤ 2**IW; need not be a power of 2).
- DEFAULT_TARGET, 10'h001, target returned on a miss.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- Ready  out  1  high once initialisation is complete.
- Rd_Req  in  1  lookup request.
- Rd_Idx  in  IW  lookup index.
- Rd_PC  in  AW  current PC, used by relative entries.
- Rd_Valid  out  1  response valid (single-cycle pulse per request).
- Rd_Target  out  AW  resolved target.
- Rd_Miss  out  1  entry unprogrammed or index out of range.
- Wr_En  in  1  program an entry.
- Wr_Idx  in  IW  entry to program.
- Wr_Data  in  AW  absolute target or two's-complement offset.
- Wr_Rel  in  1  1 = PC-relative entry, 0 = absolute entry.

Behaviour:
- Reset (Reset_n = 0 at an edge):
  - State goes to INIT and the init counter goes to 0.
  - Ready = 0, Rd_Valid = 0, Rd_Miss = 0, Rd_Target = 0.
  - Applies identically mid-operation: all entries are re-invalidated and any in-flight response is dropped.
- States: INIT, RUN.
- INIT:
  - Each cycle clears entry[cnt] to {valid=0, rel=0, data=0}, then cnt++.
  - After the cycle that clears entry DEPTH-1, the next state is RUN.
  - INIT therefore lasts exactly DEPTH cycles after Reset_n deasserts.
  - Ready is registered: it goes high on the first RUN cycle.
  - Rd_Req and Wr_En are ignored in INIT: no response, no write.
- RUN: remains in RUN until reset.
- Read latency is 1 cycle. A Rd_Req sampled at edge N produces Rd_Valid = 1 with Rd_Target/Rd_Miss during cycle N+1.
  - Rd_Valid is 0 in any cycle not preceded by a request.
  - Rd_Target and Rd_Miss hold their last values when Rd_Valid = 0.
  - Back-to-back requests give back-to-back responses; there is no stall and no backpressure.
- Target resolution:
  - If Rd_Idx ≥ DEPTH or the entry has valid = 0: Rd_Miss = 1 and Rd_Target = DEFAULT_TARGET.
  - Absolute entry: Rd_Target = data.
  - Relative entry: Rd_Target = (Rd_PC + data) mod 2**AW, with data treated as signed AW-bit. Wrap is silent; there is no overflow flag.
  - Rd_PC is sampled in the request cycle.
- Write: Wr_En in RUN sets entry[Wr_Idx] = {1, Wr_Rel, Wr_Data} at the edge.
  - Wr_Idx ≥ DEPTH is ignored.
  - Rewriting an entry overwrites it.
- Simultaneous read and write of the same index in the same cycle: the response reflects the new write (write-through forwarding).
- Same cycle as reset: reset wins.

Decomposition:
- Package lut_pkg contains:
  - enum lut_state_t {INIT, RUN};
  - struct lut_entry_t {valid, rel, data[AW]};
  - constant LUT_DEFAULT_TARGET.
- The existing LUT_def index constants move into or are imported by lut_pkg.
- Sub-module lut_target_ram: DEPTH × lut_entry_t storage with one synchronous write port and one combinational read port, no reset. The top module holds the FSM, init counter, forwarding mux, adder and output registers.

Test Plan:
- Hold Reset_n = 0 for 3 cycles, then release, with Rd_Req = 1 throughout → Ready = 0 for exactly 16 cycles and 1 on the 17th; Rd_Valid stays 0 throughout INIT.
- After Ready, read idx 5 → next cycle Rd_Valid = 1, Rd_Miss = 1, Rd_Target = 10'h001; the cycle after, Rd_Valid = 0.
- Write idx 2 absolute 10'h3C0, then read idx 2 → Rd_Target = 10'h3C0, Rd_Miss = 0.
- Write idx 3 relative 10'h3FF (−1):
  - read with Rd_PC = 10'h010 → Rd_Target = 10'h00F;
  - read with Rd_PC = 10'h000 → Rd_Target = 10'h3FF (wrap).
- In the same cycle, write idx 7 = 10'h055 and read idx 7 → response Rd_Target = 10'h055, Rd_Miss = 0.
- After programming idx 2, pulse Reset_n low for 1 cycle → Ready drops for 16 cycles; then read idx 2 → Rd_Miss = 1, Rd_Target = 10'h001.
